// File: rtl/instruction_encoder_pkg.sv
// rtl/instruction_encoder_pkg.sv - instruction kinds, MIPS opcode/funct constants and word-packing helpers
package instruction_encoder_pkg;

  // Symbolic instruction kinds accepted on the request interface; 12-15 are illegal
  typedef enum logic [3:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_ADDI = 4'd5,
    KIND_ORI  = 4'd6,
    KIND_LW   = 4'd7,
    KIND_SW   = 4'd8,
    KIND_BEQ  = 4'd9,
    KIND_BNE  = 4'd10,
    KIND_J    = 4'd11
  } instr_kind_e;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  // R-type layout: shamt is always zero for the supported operations
  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  // I-type layout: only the low 16 bits of the immediate are carried
  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm16);
    return {op, rs, rt, imm16};
  endfunction

endpackage

// File: rtl/instruction_packer.sv
// rtl/instruction_packer.sv - combinational kind+fields to 32-bit MIPS word with illegal flag
module instruction_packer
  import instruction_encoder_pkg::*;
(
  input  logic [3:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [25:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  // Select the layout by kind; unused fields never reach the word
  always_comb begin
    word_o    = 32'd0;
    illegal_o = 1'b0;
    case (kind_i)
      KIND_ADD:  word_o = pack_r(rs_i, rt_i, rd_i, FN_ADD);
      KIND_SUB:  word_o = pack_r(rs_i, rt_i, rd_i, FN_SUB);
      KIND_AND:  word_o = pack_r(rs_i, rt_i, rd_i, FN_AND);
      KIND_OR:   word_o = pack_r(rs_i, rt_i, rd_i, FN_OR);
      KIND_SLT:  word_o = pack_r(rs_i, rt_i, rd_i, FN_SLT);
      KIND_ADDI: word_o = pack_i(OP_ADDI, rs_i, rt_i, imm_i[15:0]);
      KIND_ORI:  word_o = pack_i(OP_ORI,  rs_i, rt_i, imm_i[15:0]);
      KIND_LW:   word_o = pack_i(OP_LW,   rs_i, rt_i, imm_i[15:0]);
      KIND_SW:   word_o = pack_i(OP_SW,   rs_i, rt_i, imm_i[15:0]);
      KIND_BEQ:  word_o = pack_i(OP_BEQ,  rs_i, rt_i, imm_i[15:0]);
      KIND_BNE:  word_o = pack_i(OP_BNE,  rs_i, rt_i, imm_i[15:0]);
      KIND_J:    word_o = {OP_J, imm_i};
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - session FSM packing instruction requests into consecutive imem writes
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [3:0]        enc_kind,
  input  logic [4:0]        enc_rs,
  input  logic [4:0]        enc_rt,
  input  logic [4:0]        enc_rd,
  input  logic [25:0]       enc_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_FULL   = 2'd3;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              fin_q, fin_d;

  logic [31:0]       pk_word;
  logic              pk_illegal;

  instruction_packer u_packer (
    .kind_i    (enc_kind),
    .rs_i      (enc_rs),
    .rt_i      (enc_rt),
    .rd_i      (enc_rd),
    .imm_i     (enc_imm),
    .word_o    (pk_word),
    .illegal_o (pk_illegal)
  );

  // Next-state logic: session control, address/count advance and finish tracking
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    fin_d   = fin_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCEPT;
          addr_d  = base_addr;
          count_d = '0;
          err_d   = 1'b0;
          fin_d   = 1'b0;
        end
      end
      ST_ACCEPT: begin
        // An illegal request is consumed and only flagged; a legal one carries finish along
        if (enc_valid && pk_illegal) begin
          err_d = 1'b1;
        end
        if (enc_valid && !pk_illegal) begin
          wdata_d = pk_word;
          fin_d   = finish;
          state_d = ST_WRITE;
        end else if (finish) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_WRITE: begin
        // finish raised while the write is stalled is remembered, not lost
        fin_d = fin_q | finish;
        if (imem_ready) begin
          count_d = count_q + 1'b1;
          addr_d  = addr_q + 1'b1;
          if (fin_q || finish) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (count_d == MAX_CNT) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_FULL: begin
        if (finish) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any session in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
      done_q  <= done_d;
      fin_q   <= fin_d;
    end
  end

  assign enc_ready  = (state_q == ST_ACCEPT);
  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - scoreboard bench for instruction_encoder
module tb_instruction_encoder;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              finish;
  logic              enc_valid;
  logic              enc_ready;
  logic [3:0]        enc_kind;
  logic [4:0]        enc_rs;
  logic [4:0]        enc_rt;
  logic [4:0]        enc_rd;
  logic [25:0]       enc_imm;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              error;

  exp_t              sb[$];
  logic [ADDR_W-1:0] exp_addr;
  int                err_cnt = 0;
  int                chk_cnt = 0;

  always #5 clock = ~clock;

  instruction_encoder #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .finish     (finish),
    .enc_valid  (enc_valid),
    .enc_ready  (enc_ready),
    .enc_kind   (enc_kind),
    .enc_rs     (enc_rs),
    .enc_rt     (enc_rt),
    .enc_rd     (enc_rd),
    .enc_imm    (enc_imm),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] k, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [25:0] imm);
    case (k)
      4'd0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd1:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      4'd2:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      4'd3:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4'd4:  return {6'h00, rs, rt, rd, 5'd0, 6'h2a};
      4'd5:  return {6'h08, rs, rt, imm[15:0]};
      4'd6:  return {6'h0d, rs, rt, imm[15:0]};
      4'd7:  return {6'h23, rs, rt, imm[15:0]};
      4'd8:  return {6'h2b, rs, rt, imm[15:0]};
      4'd9:  return {6'h04, rs, rt, imm[15:0]};
      4'd10: return {6'h05, rs, rt, imm[15:0]};
      4'd11: return {6'h02, imm};
      default: return 32'd0;
    endcase
  endfunction

  // Every completed write must match the oldest expected entry
  always @(negedge clock) begin
    if (reset_n && imem_we && imem_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_write", {56'd0, imem_addr}, 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("write_addr", imem_addr, e.addr);
        chk("write_data", imem_wdata, e.data);
      end
    end
  end

  task automatic start_session(input logic [ADDR_W-1:0] b);
    @(posedge clock); #1;
    start = 1'b1; base_addr = b; exp_addr = b;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [25:0] imm, input logic fin,
                      input logic [31:0] exp_w);
    int n;
    @(posedge clock); #1;
    enc_kind = k; enc_rs = rs; enc_rt = rt; enc_rd = rd; enc_imm = imm;
    enc_valid = 1'b1; finish = fin;
    n = 0;
    @(negedge clock);
    while (!enc_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!enc_ready) begin
      chk("send_ready_timeout", enc_ready, 1);
    end else if (k <= 4'd11) begin
      sb.push_back({exp_addr, exp_w});
      exp_addr = exp_addr + 1'b1;
    end
    @(posedge clock); #1;
    enc_valid = 1'b0; finish = 1'b0;
  endtask

  task automatic send_m(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [25:0] imm, input logic fin);
    send(k, rs, rt, rd, imm, fin, model(k, rs, rt, rd, imm));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk(tag, sb.size(), 0);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic finish_only();
    @(posedge clock); #1;
    finish = 1'b1;
    @(posedge clock); #1;
    finish = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int  n;
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clock);
      if (done) seen = 1'b1;
      n++;
    end
    chk(tag, seen, 1);
    chk({tag, "_busy"}, busy, 0);
    @(negedge clock);
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t tmp;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; finish = 1'b0; enc_valid = 1'b0;
    enc_kind = '0; enc_rs = '0; enc_rt = '0; enc_rd = '0; enc_imm = '0;
    imem_ready = 1'b1; exp_addr = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_enc_ready", enc_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset_n = 1'b1;

    // Session 1: R/I/J vectors, then a stalled J write that fills the session
    start_session(8'h10);
    @(negedge clock);
    chk("s1_busy", busy, 1);
    chk("s1_ready", enc_ready, 1);
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h00221820);
    drain("s1_add_drain");
    chk("s1_count1", count, 1);
    send(4'd5, 5'd0, 5'd8, 5'd31, 26'h3FF1234, 1'b0, 32'h20081234);
    send(4'd7, 5'd29, 5'd9, 5'd7, 26'd4, 1'b0, 32'h8FA90004);
    drain("s1_lw_drain");
    imem_ready = 1'b0;
    send(4'd11, 5'd5, 5'd6, 5'd7, 26'h40, 1'b0, 32'h08000040);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_we", imem_we, 1);
      chk("stall_addr", imem_addr, 8'h13);
      chk("stall_wdata", imem_wdata, 32'h08000040);
      chk("stall_ready", enc_ready, 0);
    end
    @(posedge clock); #1;
    imem_ready = 1'b1;
    drain("s1_j_drain");
    chk("s1_count_full", count, 4);
    chk("s1_full_ready", enc_ready, 0);
    chk("s1_full_busy", busy, 1);
    finish_only();
    wait_done("s1_done");

    // Session 2: illegal kind is consumed without a write, address holds
    start_session(8'h40);
    send(4'd13, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'd0);
    @(negedge clock);
    chk("ill_error", error, 1);
    chk("ill_count", count, 0);
    chk("ill_we", imem_we, 0);
    chk("ill_ready", enc_ready, 1);
    send_m(4'd6, 5'd4, 5'd5, 5'd6, 26'h00ABCD, 1'b0);
    drain("ill_drain");
    chk("ill_count_after", count, 1);
    chk("ill_error_sticky", error, 1);
    finish_only();
    wait_done("s2_done");
    start_session(8'h50);
    @(negedge clock);
    chk("restart_error_clr", error, 0);
    chk("restart_count", count, 0);
    finish_only();
    wait_done("s3_done");

    // Session 4: address wrap and FULL back-pressure
    start_session(8'hFE);
    send_m(4'd1, 5'd10, 5'd11, 5'd12, 26'd0, 1'b0);
    send_m(4'd2, 5'd13, 5'd14, 5'd15, 26'd0, 1'b0);
    send_m(4'd3, 5'd16, 5'd17, 5'd18, 26'd0, 1'b0);
    send_m(4'd4, 5'd19, 5'd20, 5'd21, 26'd0, 1'b0);
    drain("wrap_drain");
    chk("wrap_count", count, 4);
    chk("wrap_full_ready", enc_ready, 0);
    chk("wrap_full_busy", busy, 1);
    enc_valid = 1'b1;
    @(negedge clock);
    chk("full_backpressure", enc_ready, 0);
    enc_valid = 1'b0;
    finish_only();
    wait_done("wrap_done");

    // Session 5: branches, then a store carrying finish
    start_session(8'h20);
    send_m(4'd9, 5'd1, 5'd2, 5'd3, 26'h3FFFFFC, 1'b0);
    send_m(4'd10, 5'd4, 5'd5, 5'd6, 26'h0010, 1'b0);
    send_m(4'd8, 5'd29, 5'd31, 5'd0, 26'h0008, 1'b1);
    wait_done("fin_hs_done");
    chk("fin_hs_sb_empty", sb.size(), 0);
    chk("fin_hs_count", count, 3);

    // Session 6: reset while a write is stalled
    start_session(8'h30);
    imem_ready = 1'b0;
    send_m(4'd0, 5'd7, 5'd8, 5'd9, 26'd0, 1'b0);
    @(negedge clock);
    chk("pre_rst_we", imem_we, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_we", imem_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", count, 0);
    if (sb.size() != 0) tmp = sb.pop_front();
    #1 reset_n = 1'b1;
    imem_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_rst_we", imem_we, 0);
    chk("post_rst_busy", busy, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
